// File: rtl/quokka_clk_pkg.sv
// Shared types and helpers for the 6502 PHI0 clock and run-control block.
package quokka_clk_pkg;

  typedef enum logic [1:0] {
    HALT     = 2'd0,
    RUN      = 2'd1,
    STEP_CYC = 2'd2,
    STEP_INS = 2'd3
  } run_state_e;

  // A half-period of zero would stall the divider, so it is treated as one.
  function automatic int clamp_half(input int v);
    return (v <= 0) ? 1 : v;
  endfunction

endpackage

// File: rtl/phi0_ctrl_if.sv
// Keyboard-decoder/CPU-pin side signals of the PHI0 run-control block.
interface phi0_ctrl_if #(
  parameter int DIV_W = 8,
  parameter int CNT_W = 16
);
  logic [DIV_W-1:0] half_period;
  logic             run;
  logic             step_cycle;
  logic             step_instr;
  logic             sync;
  logic             phi0;
  logic             phi0_rise;
  logic             phi0_fall;
  logic             rdy;
  logic             halted;
  logic [CNT_W-1:0] cycle_cnt;

  modport master (
    output half_period, run, step_cycle, step_instr, sync,
    input  phi0, phi0_rise, phi0_fall, rdy, halted, cycle_cnt
  );

  modport slave (
    input  half_period, run, step_cycle, step_instr, sync,
    output phi0, phi0_rise, phi0_fall, rdy, halted, cycle_cnt
  );
endinterface

// File: rtl/phi0_divider.sv
// Free-running PHI0 generator; the half-period is relatched only as phi0 falls
// so every period stays symmetric.
module phi0_divider
  import quokka_clk_pkg::*;
#(
  parameter int DIV_W        = 8,
  parameter int DEFAULT_HALF = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DIV_W-1:0] half_period_i,
  output logic             phi0_o,
  output logic             phi0_rise_o,
  output logic             phi0_fall_o,
  output logic             fall_tick_o
);

  localparam logic [DIV_W-1:0] HP_RST = DIV_W'(clamp_half(DEFAULT_HALF));

  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] hp_q;
  logic [DIV_W-1:0] hp_d;
  logic             phi0_q;
  logic             rise_q;
  logic             fall_q;
  logic             toggle;

  assign hp_d        = DIV_W'(clamp_half(int'(half_period_i)));
  assign toggle      = (div_q == hp_q - 1'b1);
  // Combinational: marks the clk edge on which phi0 goes 1->0.
  assign fall_tick_o = toggle & phi0_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q  <= '0;
      hp_q   <= HP_RST;
      phi0_q <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      rise_q <= toggle & ~phi0_q;
      fall_q <= toggle & phi0_q;
      if (toggle) begin
        div_q  <= '0;
        phi0_q <= ~phi0_q;
        if (phi0_q) hp_q <= hp_d;
      end else begin
        div_q <= div_q + 1'b1;
      end
    end
  end

  assign phi0_o      = phi0_q;
  assign phi0_rise_o = rise_q;
  assign phi0_fall_o = fall_q;

endmodule

// File: rtl/phi0_ctrl.sv
// 6502 clock and run-control: PHI0 divider plus RDY gating for run, halt,
// single-cycle and single-instruction stepping.
module phi0_ctrl
  import quokka_clk_pkg::*;
#(
  parameter int DIV_W         = 8,
  parameter int CNT_W         = 16,
  parameter int DEFAULT_HALF  = 5,
  parameter bit START_RUNNING = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  phi0_ctrl_if.slave  bus
);

  localparam run_state_e ST_RST = START_RUNNING ? RUN : HALT;

  run_state_e       state_q;
  logic             rdy_q;
  logic             halted_q;
  logic             pend_cyc_q;
  logic             pend_ins_q;
  logic             seen_nosync_q;
  logic [CNT_W-1:0] cycle_cnt_q;
  logic             fall_tick;
  logic             pend_cyc_w;
  logic             pend_ins_w;

  phi0_divider #(
    .DIV_W        (DIV_W),
    .DEFAULT_HALF (DEFAULT_HALF)
  ) u_div (
    .clk           (clk),
    .rst           (rst),
    .half_period_i (bus.half_period),
    .phi0_o        (bus.phi0),
    .phi0_rise_o   (bus.phi0_rise),
    .phi0_fall_o   (bus.phi0_fall),
    .fall_tick_o   (fall_tick)
  );

  // A step pulse landing on the fall edge itself is served at that edge.
  assign pend_cyc_w = pend_cyc_q | bus.step_cycle;
  assign pend_ins_w = pend_ins_q | bus.step_instr;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_RST;
      rdy_q         <= START_RUNNING;
      halted_q      <= ~START_RUNNING;
      pend_cyc_q    <= 1'b0;
      pend_ins_q    <= 1'b0;
      seen_nosync_q <= 1'b0;
      cycle_cnt_q   <= '0;
    end else if (!fall_tick) begin
      pend_cyc_q <= pend_cyc_w;
      pend_ins_q <= pend_ins_w;
    end else begin
      if (rdy_q) cycle_cnt_q <= cycle_cnt_q + 1'b1;
      if (!bus.sync) seen_nosync_q <= 1'b1;
      pend_cyc_q <= pend_cyc_w;
      pend_ins_q <= pend_ins_w;
      if (bus.run) begin
        state_q    <= RUN;
        rdy_q      <= 1'b1;
        halted_q   <= 1'b0;
        pend_cyc_q <= 1'b0;
        pend_ins_q <= 1'b0;
      end else begin
        case (state_q)
          HALT: begin
            if (pend_ins_w) begin
              state_q       <= STEP_INS;
              rdy_q         <= 1'b1;
              halted_q      <= 1'b0;
              pend_ins_q    <= 1'b0;
              seen_nosync_q <= 1'b0;
            end else if (pend_cyc_w) begin
              state_q    <= STEP_CYC;
              rdy_q      <= 1'b1;
              halted_q   <= 1'b0;
              pend_cyc_q <= 1'b0;
            end
          end
          STEP_INS: begin
            // Stop at the opcode fetch that follows at least one non-fetch cycle.
            if (bus.sync && seen_nosync_q) begin
              state_q  <= HALT;
              rdy_q    <= 1'b0;
              halted_q <= 1'b1;
            end
          end
          default: begin
            state_q  <= HALT;
            rdy_q    <= 1'b0;
            halted_q <= 1'b1;
          end
        endcase
      end
    end
  end

  assign bus.rdy       = rdy_q;
  assign bus.halted    = halted_q;
  assign bus.cycle_cnt = cycle_cnt_q;

endmodule

// File: tb/tb_phi0_ctrl.sv
// Directed bench for phi0_ctrl: divider timing, stepping, run and reset.
module tb_phi0_ctrl;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;
  int   n;
  int   m;

  phi0_ctrl_if #(.DIV_W(8), .CNT_W(16)) bus ();

  phi0_ctrl #(
    .DIV_W         (8),
    .CNT_W         (16),
    .DEFAULT_HALF  (5),
    .START_RUNNING (1'b0)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Counts clk edges until the requested strobe is seen; bounded.
  task automatic wait_strobe(input bit rise, output int cnt);
    bit seen = 1'b0;
    cnt = 0;
    while (!seen && cnt < 200) begin
      @(posedge clk);
      #1;
      cnt++;
      seen = rise ? bus.phi0_rise : bus.phi0_fall;
    end
    if (!seen) begin
      vectors++;
      miscompares++;
      $error("FAIL timeout_%s: observed no strobe in %0d clk, expected one", rise ? "rise" : "fall", cnt);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vectors          = 0;
    miscompares      = 0;
    rst              = 1'b1;
    bus.half_period  = 8'd5;
    bus.run          = 1'b0;
    bus.step_cycle   = 1'b0;
    bus.step_instr   = 1'b0;
    bus.sync         = 1'b0;
    repeat (3) tick();

    chk("rst_phi0", 32'(bus.phi0), 0);
    chk("rst_rise", 32'(bus.phi0_rise), 0);
    chk("rst_fall", 32'(bus.phi0_fall), 0);
    chk("rst_rdy", 32'(bus.rdy), 0);
    chk("rst_halted", 32'(bus.halted), 1);
    chk("rst_cnt", 32'(bus.cycle_cnt), 0);
    rst = 1'b0;

    wait_strobe(1'b1, n); chk("first_rise", n, 5);
    chk("first_rise_phi0", 32'(bus.phi0), 1);
    wait_strobe(1'b0, n); chk("first_high", n, 5);

    // Change half_period mid-high: current period unchanged, next uses 3.
    wait_strobe(1'b1, n);
    tick();
    bus.half_period = 8'd3;
    wait_strobe(1'b0, m); chk("period_cur", n + 1 + m, 10);
    wait_strobe(1'b0, n); chk("period_hp3", n, 6);

    bus.half_period = 8'd0;
    wait_strobe(1'b0, n); chk("period_pre0", n, 6);
    wait_strobe(1'b1, n); chk("hp1_rise", n, 1);
    wait_strobe(1'b0, n); chk("hp1_fall", n, 1);
    wait_strobe(1'b0, n); chk("period_hp1", n, 2);

    bus.half_period = 8'd2;
    wait_strobe(1'b0, n); chk("period_pre2", n, 2);
    wait_strobe(1'b0, n); chk("period_hp2", n, 4);
    chk("idle_rdy", 32'(bus.rdy), 0);
    chk("idle_cnt", 32'(bus.cycle_cnt), 0);

    // step_cycle pulse coincident with a fall edge is consumed there.
    repeat (3) tick();
    bus.step_cycle = 1'b1;
    tick();
    bus.step_cycle = 1'b0;
    chk("sc_on_fall", 32'(bus.phi0_fall), 1);
    chk("sc_rdy", 32'(bus.rdy), 1);
    chk("sc_halted", 32'(bus.halted), 0);
    wait_strobe(1'b0, n); chk("sc_len", n, 4);
    chk("sc_end_rdy", 32'(bus.rdy), 0);
    chk("sc_end_halted", 32'(bus.halted), 1);
    chk("sc_cnt", 32'(bus.cycle_cnt), 1);
    wait_strobe(1'b0, n); chk("sc_hold_cnt", 32'(bus.cycle_cnt), 1);

    // step_instr with sync 1,0,0,1 at successive falls.
    bus.sync = 1'b1;
    bus.step_instr = 1'b1;
    tick();
    bus.step_instr = 1'b0;
    wait_strobe(1'b0, n); chk("si_f0_rdy", 32'(bus.rdy), 1);
    bus.sync = 1'b0;
    wait_strobe(1'b0, n); chk("si_f1_rdy", 32'(bus.rdy), 1);
    chk("si_f1_cnt", 32'(bus.cycle_cnt), 2);
    wait_strobe(1'b0, n); chk("si_f2_rdy", 32'(bus.rdy), 1);
    chk("si_f2_cnt", 32'(bus.cycle_cnt), 3);
    bus.sync = 1'b1;
    wait_strobe(1'b0, n); chk("si_f3_rdy", 32'(bus.rdy), 0);
    chk("si_f3_halted", 32'(bus.halted), 1);
    chk("si_f3_cnt", 32'(bus.cycle_cnt), 4);

    // Both steps in one clk: instruction first, then the pending cycle.
    bus.sync = 1'b0;
    bus.step_cycle = 1'b1;
    bus.step_instr = 1'b1;
    tick();
    bus.step_cycle = 1'b0;
    bus.step_instr = 1'b0;
    wait_strobe(1'b0, n); chk("both_f0_rdy", 32'(bus.rdy), 1);
    wait_strobe(1'b0, n); chk("both_ins_hold", 32'(bus.rdy), 1);
    chk("both_f1_cnt", 32'(bus.cycle_cnt), 5);
    bus.sync = 1'b1;
    wait_strobe(1'b0, n); chk("both_ins_end", 32'(bus.rdy), 0);
    chk("both_f2_cnt", 32'(bus.cycle_cnt), 6);
    wait_strobe(1'b0, n); chk("both_cyc_rdy", 32'(bus.rdy), 1);
    chk("both_cyc_halted", 32'(bus.halted), 0);
    wait_strobe(1'b0, n); chk("both_cyc_end", 32'(bus.rdy), 0);
    chk("both_f4_cnt", 32'(bus.cycle_cnt), 7);

    // Free run for four PHI0 cycles.
    bus.sync = 1'b0;
    bus.run = 1'b1;
    wait_strobe(1'b0, n); chk("run_rdy", 32'(bus.rdy), 1);
    chk("run_halted", 32'(bus.halted), 0);
    chk("run_cnt0", 32'(bus.cycle_cnt), 7);
    repeat (3) wait_strobe(1'b0, n);
    chk("run_cnt3", 32'(bus.cycle_cnt), 10);
    bus.run = 1'b0;
    wait_strobe(1'b0, n); chk("run_stop_halted", 32'(bus.halted), 1);
    chk("run_stop_cnt", 32'(bus.cycle_cnt), 11);

    // Reset in the middle of an instruction step with a cycle step pending.
    bus.step_instr = 1'b1;
    tick();
    bus.step_instr = 1'b0;
    wait_strobe(1'b0, n); chk("si2_rdy", 32'(bus.rdy), 1);
    bus.step_cycle = 1'b1;
    tick();
    bus.step_cycle = 1'b0;
    rst = 1'b1;
    tick();
    chk("mid_rst_rdy", 32'(bus.rdy), 0);
    chk("mid_rst_phi0", 32'(bus.phi0), 0);
    chk("mid_rst_cnt", 32'(bus.cycle_cnt), 0);
    chk("mid_rst_halted", 32'(bus.halted), 1);
    rst = 1'b0;
    wait_strobe(1'b1, n); chk("post_rst_rise", n, 5);
    wait_strobe(1'b0, n); chk("post_rst_high", n, 5);
    chk("post_rst_pend_clr", 32'(bus.rdy), 0);
    wait_strobe(1'b0, n); chk("post_rst_period", n, 4);
    chk("post_rst_halted", 32'(bus.halted), 1);
    chk("post_rst_cnt", 32'(bus.cycle_cnt), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
